// File: rtl/seq_signed_mult.sv
// Sequential shift-add multiplier over operand magnitudes, signed or unsigned.
// Reports the two's complement product plus sign/magnitude and the iteration count.
module seq_signed_mult #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          EARLY_TERM = 1'b1,
  parameter int unsigned CW         = $clog2(WIDTH + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               signed_mode_i,
  input  logic [WIDTH-1:0]   multiplicand_i,
  input  logic [WIDTH-1:0]   multiplier_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o,
  output logic [2*WIDTH-1:0] magnitude_o,
  output logic               sign_o,
  output logic [CW-1:0]      cycles_o
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sign_pend_q, sign_pend_d;
  logic [PW-1:0]     product_q, product_d;
  logic [PW-1:0]     magnitude_q, magnitude_d;
  logic              sign_q, sign_d;
  logic [CW-1:0]     cycles_q, cycles_d;

  logic [WIDTH-1:0]  mag_a, mag_b;
  logic [PW-1:0]     acc_nx;
  logic [WIDTH-1:0]  mplier_nx;
  logic [CW-1:0]     cnt_nx;
  logic              last_iter;
  logic              neg;

  // Operand magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits unsigned.
  always_comb begin
    mag_a = (signed_mode_i && multiplicand_i[WIDTH-1]) ? (~multiplicand_i + WIDTH'(1))
                                                       : multiplicand_i;
    mag_b = (signed_mode_i && multiplier_i[WIDTH-1]) ? (~multiplier_i + WIDTH'(1))
                                                     : multiplier_i;
  end

  always_comb begin
    acc_nx    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mplier_nx = mplier_q >> 1;
    cnt_nx    = cnt_q + CW'(1);
    last_iter = (cnt_nx == CW'(WIDTH)) || (EARLY_TERM && (mplier_nx == '0));
    neg       = sign_pend_q && (acc_nx != '0);
  end

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sign_pend_d = sign_pend_q;
    product_d   = product_q;
    magnitude_d = magnitude_q;
    sign_d      = sign_q;
    cycles_d    = cycles_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          mcand_d     = {{WIDTH{1'b0}}, mag_a};
          mplier_d    = mag_b;
          acc_d       = '0;
          cnt_d       = '0;
          sign_pend_d = signed_mode_i && (multiplicand_i[WIDTH-1] ^ multiplier_i[WIDTH-1]);
          state_d     = StRun;
        end
      end
      StRun: begin
        acc_d    = acc_nx;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_nx;
        cnt_d    = cnt_nx;
        if (last_iter) begin
          // Results are published on entry to DONE and held until the next one.
          state_d     = StDone;
          magnitude_d = acc_nx;
          sign_d      = neg;
          product_d   = neg ? (~acc_nx + PW'(1)) : acc_nx;
          cycles_d    = cnt_nx;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      sign_pend_q <= 1'b0;
      product_q   <= '0;
      magnitude_q <= '0;
      sign_q      <= 1'b0;
      cycles_q    <= '0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sign_pend_q <= sign_pend_d;
      product_q   <= product_d;
      magnitude_q <= magnitude_d;
      sign_q      <= sign_d;
      cycles_q    <= cycles_d;
    end
  end

  assign busy_o      = (state_q == StRun);
  assign done_o      = (state_q == StDone);
  assign product_o   = product_q;
  assign magnitude_o = magnitude_q;
  assign sign_o      = sign_q;
  assign cycles_o    = cycles_q;

endmodule

// File: tb/tb_seq_signed_mult.sv
// Directed bench: 8-bit with and without early termination, plus a 16-bit instance.
module tb_seq_signed_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start_r [3];
  logic        sm_r    [3];
  logic [15:0] a_r     [3];
  logic [15:0] b_r     [3];

  logic        busy_w  [3];
  logic        done_w  [3];
  logic        sign_w  [3];
  logic [31:0] prod_w  [3];
  logic [31:0] mag_w   [3];
  logic [7:0]  cyc_w   [3];

  logic [15:0] p0, p1, m0, m1;
  logic [31:0] p2, m2;
  logic [3:0]  c0, c1;
  logic [4:0]  c2;

  int checks = 0;
  int errors = 0;

  seq_signed_mult #(.WIDTH(8), .EARLY_TERM(1'b1)) u_et1 (
    .clk_i(clk), .reset_i(reset), .start_i(start_r[0]), .signed_mode_i(sm_r[0]),
    .multiplicand_i(a_r[0][7:0]), .multiplier_i(b_r[0][7:0]),
    .busy_o(busy_w[0]), .done_o(done_w[0]), .product_o(p0), .magnitude_o(m0),
    .sign_o(sign_w[0]), .cycles_o(c0)
  );

  seq_signed_mult #(.WIDTH(8), .EARLY_TERM(1'b0)) u_et0 (
    .clk_i(clk), .reset_i(reset), .start_i(start_r[1]), .signed_mode_i(sm_r[1]),
    .multiplicand_i(a_r[1][7:0]), .multiplier_i(b_r[1][7:0]),
    .busy_o(busy_w[1]), .done_o(done_w[1]), .product_o(p1), .magnitude_o(m1),
    .sign_o(sign_w[1]), .cycles_o(c1)
  );

  seq_signed_mult #(.WIDTH(16), .EARLY_TERM(1'b1)) u_w16 (
    .clk_i(clk), .reset_i(reset), .start_i(start_r[2]), .signed_mode_i(sm_r[2]),
    .multiplicand_i(a_r[2]), .multiplier_i(b_r[2]),
    .busy_o(busy_w[2]), .done_o(done_w[2]), .product_o(p2), .magnitude_o(m2),
    .sign_o(sign_w[2]), .cycles_o(c2)
  );

  assign prod_w[0] = {16'h0, p0};
  assign prod_w[1] = {16'h0, p1};
  assign prod_w[2] = p2;
  assign mag_w[0]  = {16'h0, m0};
  assign mag_w[1]  = {16'h0, m1};
  assign mag_w[2]  = m2;
  assign cyc_w[0]  = {4'h0, c0};
  assign cyc_w[1]  = {4'h0, c1};
  assign cyc_w[2]  = {3'h0, c2};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation and check latency, pulse width and all result outputs.
  task automatic do_op(input int sel, input logic sm, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] ep, input logic [31:0] em, input logic es,
                       input int ec, input int elat);
    int lat;
    @(negedge clk);
    sm_r[sel] = sm; a_r[sel] = a; b_r[sel] = b; start_r[sel] = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        start_r[sel] = 1'b0;
        chk("busy_run", 32'(busy_w[sel]), 32'd1);
      end
    end while (!done_w[sel] && lat < 100);
    chk("latency", 32'(lat), 32'(elat));
    chk("busy_done", 32'(busy_w[sel]), 32'd0);
    chk("product", prod_w[sel], ep);
    chk("magnitude", mag_w[sel], em);
    chk("sign", 32'(sign_w[sel]), 32'(es));
    chk("cycles", 32'(cyc_w[sel]), 32'(ec));
    @(negedge clk);
    chk("done_width", 32'(done_w[sel]), 32'd0);
    chk("product_hold", prod_w[sel], ep);
  endtask

  initial begin
    int lat;
    int ndone;
    for (int i = 0; i < 3; i++) begin
      start_r[i] = 1'b0; sm_r[i] = 1'b0; a_r[i] = '0; b_r[i] = '0;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy", 32'(busy_w[i]), 32'd0);
      chk("rst_done", 32'(done_w[i]), 32'd0);
      chk("rst_product", prod_w[i], 32'd0);
      chk("rst_cycles", 32'(cyc_w[i]), 32'd0);
    end
    reset = 1'b0;

    // 8-bit, early termination
    do_op(0, 1'b1, 16'h00FD, 16'h0005, 32'h0000FFF1, 32'h000F, 1'b1, 3, 4);
    do_op(0, 1'b1, 16'h0080, 16'h0080, 32'h00004000, 32'h4000, 1'b0, 8, 9);
    do_op(0, 1'b0, 16'h00FF, 16'h00FF, 32'h0000FE01, 32'hFE01, 1'b0, 8, 9);
    do_op(0, 1'b1, 16'h00F9, 16'h0000, 32'h00000000, 32'h0000, 1'b0, 1, 2);
    do_op(0, 1'b1, 16'h00FD, 16'h00FB, 32'h0000000F, 32'h000F, 1'b0, 3, 4);
    do_op(0, 1'b1, 16'h007F, 16'h0081, 32'h0000C0FF, 32'h3F01, 1'b1, 7, 8);
    do_op(0, 1'b0, 16'h0080, 16'h0003, 32'h00000180, 32'h0180, 1'b0, 2, 3);

    // 8-bit, fixed iteration count
    do_op(1, 1'b1, 16'h00F9, 16'h0000, 32'h00000000, 32'h0000, 1'b0, 8, 9);
    do_op(1, 1'b1, 16'h00FD, 16'h0005, 32'h0000FFF1, 32'h000F, 1'b1, 8, 9);

    // Start re-pulsed in RUN and in DONE must be ignored
    @(negedge clk);
    sm_r[0] = 1'b1; a_r[0] = 16'h0006; b_r[0] = 16'h0007; start_r[0] = 1'b1;
    lat = 0; ndone = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        start_r[0] = 1'b1; a_r[0] = 16'h0001; b_r[0] = 16'h0001;
      end else begin
        start_r[0] = 1'b0;
      end
    end while (!done_w[0] && lat < 100);
    ndone++;
    chk("ign_latency", 32'(lat), 32'd4);
    chk("ign_product", prod_w[0], 32'h002A);
    chk("ign_cycles", 32'(cyc_w[0]), 32'd3);
    start_r[0] = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0;
    chk("ign_done_busy", 32'(busy_w[0]), 32'd0);
    for (int i = 0; i < 6; i++) begin
      if (done_w[0]) ndone++;
      @(negedge clk);
    end
    chk("ign_done_count", 32'(ndone), 32'd1);
    chk("ign_product_hold", prod_w[0], 32'h002A);
    do_op(0, 1'b1, 16'h0001, 16'h0001, 32'h00000001, 32'h0001, 1'b0, 1, 2);

    // Reset on the third RUN cycle discards the operation
    @(negedge clk);
    sm_r[0] = 1'b1; a_r[0] = 16'h009C; b_r[0] = 16'h009C; start_r[0] = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_busy", 32'(busy_w[0]), 32'd0);
    chk("mid_rst_done", 32'(done_w[0]), 32'd0);
    chk("mid_rst_product", prod_w[0], 32'd0);
    chk("mid_rst_magnitude", mag_w[0], 32'd0);
    chk("mid_rst_sign", 32'(sign_w[0]), 32'd0);
    chk("mid_rst_cycles", 32'(cyc_w[0]), 32'd0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done_w[0]) ndone++;
    end
    chk("mid_rst_nodone", 32'(ndone), 32'd0);
    do_op(0, 1'b1, 16'h009C, 16'h009C, 32'h00002710, 32'h2710, 1'b0, 7, 8);

    // 16-bit instance
    do_op(2, 1'b1, 16'h8000, 16'h8000, 32'h40000000, 32'h40000000, 1'b0, 16, 17);
    do_op(2, 1'b1, 16'hFFFF, 16'h0003, 32'hFFFFFFFD, 32'h00000003, 1'b1, 2, 3);
    do_op(2, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 32'hFFFE0001, 1'b0, 16, 17);
    do_op(2, 1'b1, 16'h0005, 16'hFFFA, 32'hFFFFFFE2, 32'h0000001E, 1'b1, 3, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
